// File: rtl/game_fsm.sv
// rtl/game_fsm.sv - game-flow controller: button debounce, dino/hazard hit detection,
// IDLE/RUN/DEAD/OVER sequencing with frame-aligned transitions
module game_fsm #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int DEAD_FRAMES     = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       leftbtn,
   input  logic       rightbtn,
   input  logic       upbtn,
   input  logic       downbtn,
   input  logic       debug,
   input  logic       frame_start,
   input  logic       dino_px,
   input  logic       hazard_px,
   output logic [1:0] game_state,
   output logic       halt,
   output logic       game_reset,
   output logic       btn_any
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DEAD = 2'd2,
      S_OVER = 2'd3
   } state_t;

   localparam int            CW        = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0]    DEAD_LAST = 8'(DEAD_FRAMES - 1);

   logic [4:0]    sync_q1;
   logic [4:0]    sync_q2;
   logic          raw_any;
   logic          debug_s;
   logic [CW-1:0] db_cnt;
   logic          btn_any_q;
   logic          press;
   logic          hit;
   logic          hit_latch;
   logic [7:0]    dead_cnt;
   state_t        state;
   state_t        next_state;
   logic          enter_run;
   logic          enter_dead;
   logic          halt_d;

   assign raw_any    = |sync_q2[3:0];
   assign debug_s    = sync_q2[4];
   assign press      = btn_any & ~btn_any_q;
   assign hit        = (state == S_RUN) & dino_px & hazard_px;
   assign game_state = state;

   // Two-flop synchronizers; bit 4 carries debug.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= {debug, downbtn, upbtn, rightbtn, leftbtn};
         sync_q2 <= sync_q1;
      end
   end

   // Accept a new level only after it has disagreed with btn_any for DEBOUNCE_CYCLES samples.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_cnt    <= '0;
         btn_any   <= 1'b0;
         btn_any_q <= 1'b0;
      end else begin
         btn_any_q <= btn_any;
         if (raw_any == btn_any) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db_cnt  <= '0;
            btn_any <= raw_any;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_latch <= 1'b0;
         dead_cnt  <= '0;
      end else begin
         if (enter_run)
            hit_latch <= 1'b0;
         else if (hit)
            hit_latch <= 1'b1;

         if (enter_dead)
            dead_cnt <= '0;
         else if (state == S_DEAD && frame_start)
            dead_cnt <= dead_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_IDLE;
         halt       <= 1'b0;
         game_reset <= 1'b0;
      end else begin
         state      <= next_state;
         halt       <= halt_d;
         game_reset <= enter_run;
      end
   end

   // Debug at a frame boundary overrides everything, including a simultaneous press.
   always_comb begin
      next_state = state;
      if (frame_start && debug_s) begin
         next_state = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_OVER: if (press) next_state = S_RUN;
            S_RUN:          if (frame_start && (hit_latch || hit)) next_state = S_DEAD;
            S_DEAD:         if (frame_start && dead_cnt == DEAD_LAST) next_state = S_OVER;
            default:        next_state = state;
         endcase
      end
   end

   always_comb begin
      enter_run  = (next_state == S_RUN) && (state != S_RUN);
      enter_dead = (next_state == S_DEAD) && (state != S_DEAD);
      halt_d     = (next_state == S_DEAD) || (next_state == S_OVER);
   end

endmodule

// File: tb/tb_game_fsm.sv
// tb/tb_game_fsm.sv - self-checking bench for game_fsm
`timescale 1ns/1ps
module tb_game_fsm;

   localparam int DEB   = 4;
   localparam int DEADF = 3;
   localparam int FRAME = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] btns = 4'b0000;   // {down, up, right, left}
   logic       debug = 1'b0;
   logic       frame_start = 1'b0;
   logic       dino_px = 1'b0;
   logic       hazard_px = 1'b0;
   logic [1:0] game_state;
   logic       halt;
   logic       game_reset;
   logic       btn_any;

   always #5 clk = ~clk;

   game_fsm #(.DEBOUNCE_CYCLES(DEB), .DEAD_FRAMES(DEADF)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .leftbtn    (btns[0]),
      .rightbtn   (btns[1]),
      .upbtn      (btns[2]),
      .downbtn    (btns[3]),
      .debug      (debug),
      .frame_start(frame_start),
      .dino_px    (dino_px),
      .hazard_px  (hazard_px),
      .game_state (game_state),
      .halt       (halt),
      .game_reset (game_reset),
      .btn_any    (btn_any)
   );

   int n_checks = 0;
   int n_errors = 0;
   int fpos = 0;

   // Reference model: states 0..3 as plain ints, raw samples delayed through a 2-entry line.
   logic [4:0] m_line [2];
   int m_state, m_disagree, m_frames_dead;
   bit m_btn, m_just_rose, m_hit_seen, m_greset;

   task automatic model_reset();
      m_line[0] = '0; m_line[1] = '0;
      m_state = 0; m_disagree = 0; m_frames_dead = 0;
      m_btn = 0; m_just_rose = 0; m_hit_seen = 0; m_greset = 0;
   endtask

   task automatic model_update();
      bit seen_any, seen_dbg, press, hit;
      int ns;
      seen_any = |m_line[1][3:0];
      seen_dbg = m_line[1][4];
      press    = m_just_rose;
      hit      = (m_state == 1) && dino_px && hazard_px;
      ns = m_state;
      if (frame_start && seen_dbg)                                  ns = 0;
      else if ((m_state == 0 || m_state == 3) && press)             ns = 1;
      else if (m_state == 1 && frame_start && (m_hit_seen || hit))  ns = 2;
      else if (m_state == 2 && frame_start && m_frames_dead + 1 == DEADF) ns = 3;
      if (m_state == 2 && frame_start) m_frames_dead++;
      if (ns == 2 && m_state != 2) m_frames_dead = 0;
      if (ns == 1 && m_state != 1) m_hit_seen = 0;
      else if (hit) m_hit_seen = 1;
      m_greset = (ns == 1) && (m_state != 1);
      m_state  = ns;
      m_just_rose = 0;
      if (seen_any != m_btn) begin
         m_disagree++;
         if (m_disagree == DEB) begin
            m_btn = seen_any;
            m_disagree = 0;
            m_just_rose = seen_any;
         end
      end else begin
         m_disagree = 0;
      end
      m_line[1] = m_line[0];
      m_line[0] = {debug, btns};
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      frame_start = (fpos == FRAME - 1);
      fpos = (fpos + 1) % FRAME;
      @(posedge clk);
      model_update();
      #1;
      chk("model_state", int'(game_state), m_state);
      chk("model_halt", int'(halt), int'(m_state >= 2));
      chk("model_game_reset", int'(game_reset), int'(m_greset));
      chk("model_btn_any", int'(btn_any), int'(m_btn));
   endtask

   task automatic run_seg(input int hold, output int gr_cnt, output int rise_at);
      bit prev;
      prev = btn_any;
      gr_cnt = 0;
      rise_at = 0;
      for (int i = 1; i <= hold; i++) begin
         step();
         if (game_reset) gr_cnt++;
         if (btn_any && !prev && rise_at == 0) rise_at = i;
         prev = btn_any;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      btns = '0; debug = 0; dino_px = 0; hazard_px = 0; frame_start = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      fpos = 0;
   endtask

   typedef struct {
      logic [3:0] btns;
      logic       dbg;
      logic       dino;
      logic       haz;
      int         hold;
      int         exp_state;
      int         exp_halt;
      int         exp_btn;
      int         exp_gr;
      int         exp_rise;
   } vec_t;

   vec_t tbl [23];

   initial begin
      int gr, rise;

      // {btns, dbg, dino, haz, hold, state, halt, btn_any, game_reset count, btn rise step}
      tbl[0]  = '{4'b0000, 0, 0, 0,  10, 0, 0, 0, 0, 0};
      tbl[1]  = '{4'b0100, 0, 0, 0,   2, 0, 0, 0, 0, 0};
      tbl[2]  = '{4'b0000, 0, 0, 0,  10, 0, 0, 0, 0, 0};
      tbl[3]  = '{4'b0100, 0, 0, 0,  10, 1, 0, 1, 1, 6};
      tbl[4]  = '{4'b0000, 0, 0, 0,  30, 1, 0, 0, 0, 0};
      tbl[5]  = '{4'b0000, 0, 0, 0,  77, 1, 0, 0, 0, 0};
      tbl[6]  = '{4'b0000, 0, 1, 1,   1, 1, 0, 0, 0, 0};
      tbl[7]  = '{4'b0000, 0, 0, 0,  59, 1, 0, 0, 0, 0};
      tbl[8]  = '{4'b0000, 0, 0, 0,   1, 2, 1, 0, 0, 0};
      tbl[9]  = '{4'b0000, 0, 0, 0, 200, 2, 1, 0, 0, 0};
      tbl[10] = '{4'b0000, 0, 0, 0, 100, 3, 1, 0, 0, 0};
      tbl[11] = '{4'b0001, 0, 0, 0,  10, 1, 0, 1, 1, 6};
      tbl[12] = '{4'b0000, 0, 0, 0,  89, 1, 0, 0, 0, 0};
      tbl[13] = '{4'b0000, 0, 1, 1,   1, 2, 1, 0, 0, 0};
      tbl[14] = '{4'b0000, 0, 0, 0, 300, 3, 1, 0, 0, 0};
      tbl[15] = '{4'b1000, 0, 0, 0,  10, 1, 0, 1, 1, 6};
      tbl[16] = '{4'b0000, 0, 1, 0, 190, 1, 0, 0, 0, 0};
      tbl[17] = '{4'b0000, 1, 0, 0,  99, 1, 0, 0, 0, 0};
      tbl[18] = '{4'b0000, 1, 0, 0,   1, 0, 0, 0, 0, 0};
      tbl[19] = '{4'b0000, 0, 0, 0,  10, 0, 0, 0, 0, 0};
      tbl[20] = '{4'b0100, 0, 0, 0,  10, 1, 0, 1, 1, 6};
      tbl[21] = '{4'b0000, 0, 1, 1,   1, 1, 0, 1, 0, 0};
      tbl[22] = '{4'b0000, 0, 0, 0, 229, 2, 1, 0, 0, 0};

      // Reset state, then a long idle stretch.
      do_reset();
      chk("reset_state", int'(game_state), 0);
      chk("reset_btn_any", int'(btn_any), 0);
      run_seg(500, gr, rise);
      chk("idle_state", int'(game_state), 0);
      chk("idle_halt", int'(halt), 0);
      chk("idle_btn_any", int'(btn_any), 0);
      chk("idle_game_reset_count", gr, 0);

      do_reset();
      for (int i = 0; i < 23; i++) begin
         btns = tbl[i].btns;
         debug = tbl[i].dbg;
         dino_px = tbl[i].dino;
         hazard_px = tbl[i].haz;
         run_seg(tbl[i].hold, gr, rise);
         chk($sformatf("v%0d_state", i), int'(game_state), tbl[i].exp_state);
         chk($sformatf("v%0d_halt", i), int'(halt), tbl[i].exp_halt);
         chk($sformatf("v%0d_btn_any", i), int'(btn_any), tbl[i].exp_btn);
         chk($sformatf("v%0d_game_reset_count", i), gr, tbl[i].exp_gr);
         chk($sformatf("v%0d_btn_rise_step", i), rise, tbl[i].exp_rise);
      end
      dino_px = 0; hazard_px = 0; btns = '0; debug = 0;

      // Asynchronous reset in DEAD, between clock edges.
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_reset_state", int'(game_state), 0);
      chk("async_reset_halt", int'(halt), 0);
      chk("async_reset_game_reset", int'(game_reset), 0);
      chk("async_reset_btn_any", int'(btn_any), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      fpos = 0;
      btns = 4'b0010;
      run_seg(10, gr, rise);
      chk("post_reset_btn_rise_step", rise, 6);
      chk("post_reset_game_reset_count", gr, 1);
      chk("post_reset_state", int'(game_state), 1);
      btns = '0;
      run_seg(20, gr, rise);

      // Randomized stimulus against the model.
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 19) == 0) btns = btns ^ (4'b0001 << $urandom_range(0, 3));
         if ($urandom_range(0, 399) == 0) debug = ~debug;
         dino_px = ($urandom_range(0, 9) == 0);
         hazard_px = ($urandom_range(0, 9) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/game_fsm.md
Name: game_fsm

Overview:
- Game-flow controller sitting directly upstream of the pixel-layer/compositing main block.
- Debounces the four direction buttons and produces a single start/restart press event.
- Detects dino-vs-hazard pixel overlap during scan-out and sequences IDLE -> RUN -> DEAD -> OVER.
- Drives game_state, halt and a one-cycle game_reset pulse to the movement, score and asteroid blocks; all state changes land on frame boundaries.

Parameters:
- DEBOUNCE_CYCLES, 250000, cycles a synced button level must hold before it is accepted (10 ms at 25 MHz); legal range 2..2^18-1.
- DEAD_FRAMES, 60, number of frame_start pulses spent in DEAD before OVER; legal range 1..255.

Ports:
- clk, input, 1: 25 MHz pixel clock (divided clock); sole clock.
- reset, input, 1: asynchronous, active-low reset.
- leftbtn, input, 1: raw asynchronous button.
- rightbtn, input, 1: raw asynchronous button.
- upbtn, input, 1: raw asynchronous button.
- downbtn, input, 1: raw asynchronous button.
- debug, input, 1: raw asynchronous level; forces return to IDLE.
- frame_start, input, 1: one-cycle pulse from the VGA timing block at the first blanking line after the visible area.
- dino_px, input, 1: dinosaur layer pixel for the current scan position.
- hazard_px, input, 1: OR of all cactus and asteroid layer pixels for the same scan position and cycle.
- game_state, output, 2: 0=IDLE, 1=RUN, 2=DEAD, 3=OVER.
- halt, output, 1: high in DEAD and OVER.
- game_reset, output, 1: one-cycle pulse on each entry into RUN.
- btn_any, output, 1: debounced OR of the four buttons.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, game_state=0, halt=0, game_reset=0, btn_any=0. Debounce counter, dead-frame counter, hit latch and all synchronizer flops clear.
- Synchronization: each button and debug passes through a 2-flop synchronizer. raw_any = OR of the four synced buttons.
- Debounce:
  - If raw_any equals btn_any, the counter resets to 0.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, btn_any takes raw_any and the counter clears.
  - Total latency from a clean raw edge to btn_any: 2 + DEBOUNCE_CYCLES cycles.
- press: internal one-cycle pulse on the 0->1 edge of btn_any. A button held through reset release yields a press once debounce completes.
- Hit detection: hit = dino_px & hazard_px, evaluated every cycle while in RUN. hit_latch sets on hit and clears on every entry into RUN.
- State transitions (registered, all outputs registered):
  - IDLE: press -> RUN.
  - RUN: frame_start & (hit_latch | hit) -> DEAD. A hit in the same cycle as frame_start counts.
  - DEAD: the dead-frame counter clears on entry and increments on each frame_start. When it reaches DEAD_FRAMES on a frame_start -> OVER. Presses are ignored.
  - OVER: press -> RUN.
  - Debug: in any state, synced debug high at frame_start -> IDLE. Debug has priority over every other transition in that cycle.
- game_reset is high exactly in the first cycle game_state reads 1 after entering from IDLE or OVER; it is never asserted otherwise.
- halt is a registered decode of the next state, so it changes in the same cycle as game_state.
- Mid-frame: no transition other than IDLE->RUN or OVER->RUN occurs outside frame_start. A press arriving during any frame takes effect immediately.
- A press and a debug frame_start in the same cycle resolve to IDLE.

Test Plan (DEBOUNCE_CYCLES=4, DEAD_FRAMES=3, frame_start every 100 cycles):
- Reset release, no input, 500 cycles -> game_state=0, halt=0, game_reset never high, btn_any=0.
- upbtn high for 2 cycles then low -> btn_any stays 0 (bounce rejected). upbtn held 10 cycles -> btn_any rises 6 cycles after the edge, game_state=1 and game_reset high for exactly 1 cycle.
- In RUN, dino_px=hazard_px=1 for one cycle at cycle 40 of a frame -> game_state stays 1 until the next frame_start, then 2 with halt=1. Three further frame_starts -> game_state=3.
- In RUN, overlap coinciding with frame_start -> game_state=2 in the next cycle. dino_px=1 with hazard_px=0 for a full frame -> remains 1.
- In OVER, leftbtn press -> game_state=1, halt=0, game_reset pulse. A debug pulse held across frame_start in RUN -> game_state=0 at that frame_start.
- Assert reset low while in DEAD mid-count -> all outputs 0 immediately, without a clock edge. After release, a rightbtn press must still need 6 cycles to reach RUN.
